// File: rtl/mem_stage.sv
// Memory stage: runs one data-memory access per load/store and registers results into MEM/WB.
// A misaligned access or a halt instruction parks the stage in HALTED until reset.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [15:0] ex_PC,
    input  logic [15:0] ex_aluOut,
    input  logic [15:0] ex_specOps,
    input  logic [15:0] ex_storeData,
    input  logic        ex_memRead,
    input  logic        ex_memWrite,
    input  logic [1:0]  ex_regSrc,
    input  logic        ex_regWrite,
    input  logic [2:0]  ex_writeReg,
    input  logic        ex_halt,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        wb_valid,
    output logic [15:0] wb_PC,
    output logic [15:0] wb_readData,
    output logic [15:0] wb_aluOut,
    output logic [15:0] wb_specOps,
    output logic [1:0]  wb_regSrc,
    output logic        wb_regWrite,
    output logic [2:0]  wb_writeReg,
    output logic        wb_halt,
    output logic        stall,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic        err_q, err_d;
    logic [15:0] acc_addr_q, acc_addr_d;
    logic [15:0] acc_wdata_q, acc_wdata_d;
    logic        acc_rd_q, acc_rd_d;

    logic [15:0] p_PC_q, p_PC_d;
    logic [15:0] p_aluOut_q, p_aluOut_d;
    logic [15:0] p_specOps_q, p_specOps_d;
    logic [1:0]  p_regSrc_q, p_regSrc_d;
    logic        p_regWrite_q, p_regWrite_d;
    logic [2:0]  p_writeReg_q, p_writeReg_d;

    logic        wb_valid_q, wb_valid_d;
    logic [15:0] wb_PC_q, wb_PC_d;
    logic [15:0] wb_readData_q, wb_readData_d;
    logic [15:0] wb_aluOut_q, wb_aluOut_d;
    logic [15:0] wb_specOps_q, wb_specOps_d;
    logic [1:0]  wb_regSrc_q, wb_regSrc_d;
    logic        wb_regWrite_q, wb_regWrite_d;
    logic [2:0]  wb_writeReg_q, wb_writeReg_d;
    logic        wb_halt_q, wb_halt_d;

    logic        memop;
    logic        misaligned;
    logic        start_access;
    logic        stall_c;

    assign memop        = ex_valid & (ex_memRead | ex_memWrite);
    assign misaligned   = memop & ex_aluOut[0];
    // Halt outranks a memory op, so an access only starts for an aligned, non-halting memop.
    assign start_access = memop & ~ex_aluOut[0] & ~ex_halt;

    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        acc_addr_d    = acc_addr_q;
        acc_wdata_d   = acc_wdata_q;
        acc_rd_d      = acc_rd_q;
        p_PC_d        = p_PC_q;
        p_aluOut_d    = p_aluOut_q;
        p_specOps_d   = p_specOps_q;
        p_regSrc_d    = p_regSrc_q;
        p_regWrite_d  = p_regWrite_q;
        p_writeReg_d  = p_writeReg_q;
        wb_valid_d    = wb_valid_q;
        wb_PC_d       = wb_PC_q;
        wb_readData_d = wb_readData_q;
        wb_aluOut_d   = wb_aluOut_q;
        wb_specOps_d  = wb_specOps_q;
        wb_regSrc_d   = wb_regSrc_q;
        wb_regWrite_d = wb_regWrite_q;
        wb_writeReg_d = wb_writeReg_q;
        wb_halt_d     = wb_halt_q;
        stall_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!ex_valid) begin
                    wb_valid_d    = 1'b0;
                    wb_regWrite_d = 1'b0;
                    wb_halt_d     = 1'b0;
                end else if (start_access) begin
                    stall_c      = 1'b1;
                    acc_addr_d   = ex_aluOut;
                    acc_wdata_d  = ex_storeData;
                    acc_rd_d     = ex_memRead;
                    p_PC_d       = ex_PC;
                    p_aluOut_d   = ex_aluOut;
                    p_specOps_d  = ex_specOps;
                    p_regSrc_d   = ex_regSrc;
                    p_regWrite_d = ex_regWrite;
                    p_writeReg_d = ex_writeReg;
                    wb_valid_d   = 1'b0;
                    state_d      = ACCESS;
                end else begin
                    wb_valid_d    = 1'b1;
                    wb_PC_d       = ex_PC;
                    wb_readData_d = '0;
                    wb_aluOut_d   = ex_aluOut;
                    wb_specOps_d  = ex_specOps;
                    wb_regSrc_d   = ex_regSrc;
                    wb_regWrite_d = ex_regWrite;
                    wb_writeReg_d = ex_writeReg;
                    wb_halt_d     = ex_halt;
                    if (ex_halt) begin
                        state_d = HALTED;
                    end else if (misaligned) begin
                        wb_regWrite_d = 1'b0;
                        wb_halt_d     = 1'b1;
                        err_d         = 1'b1;
                        state_d       = HALTED;
                    end
                end
            end
            ACCESS: begin
                stall_c = ~mem_done;
                if (mem_done) begin
                    wb_valid_d    = 1'b1;
                    wb_PC_d       = p_PC_q;
                    wb_readData_d = acc_rd_q ? mem_rdata : '0;
                    wb_aluOut_d   = p_aluOut_q;
                    wb_specOps_d  = p_specOps_q;
                    wb_regSrc_d   = p_regSrc_q;
                    wb_regWrite_d = p_regWrite_q;
                    wb_writeReg_d = p_writeReg_q;
                    wb_halt_d     = 1'b0;
                    state_d       = IDLE;
                end else begin
                    wb_valid_d = 1'b0;
                end
            end
            HALTED: begin
                stall_c    = 1'b1;
                wb_valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q         <= 1'b0;
            acc_addr_q    <= '0;
            acc_wdata_q   <= '0;
            acc_rd_q      <= 1'b0;
            p_PC_q        <= '0;
            p_aluOut_q    <= '0;
            p_specOps_q   <= '0;
            p_regSrc_q    <= '0;
            p_regWrite_q  <= 1'b0;
            p_writeReg_q  <= '0;
            wb_valid_q    <= 1'b0;
            wb_PC_q       <= '0;
            wb_readData_q <= '0;
            wb_aluOut_q   <= '0;
            wb_specOps_q  <= '0;
            wb_regSrc_q   <= '0;
            wb_regWrite_q <= 1'b0;
            wb_writeReg_q <= '0;
            wb_halt_q     <= 1'b0;
        end else begin
            err_q         <= err_d;
            acc_addr_q    <= acc_addr_d;
            acc_wdata_q   <= acc_wdata_d;
            acc_rd_q      <= acc_rd_d;
            p_PC_q        <= p_PC_d;
            p_aluOut_q    <= p_aluOut_d;
            p_specOps_q   <= p_specOps_d;
            p_regSrc_q    <= p_regSrc_d;
            p_regWrite_q  <= p_regWrite_d;
            p_writeReg_q  <= p_writeReg_d;
            wb_valid_q    <= wb_valid_d;
            wb_PC_q       <= wb_PC_d;
            wb_readData_q <= wb_readData_d;
            wb_aluOut_q   <= wb_aluOut_d;
            wb_specOps_q  <= wb_specOps_d;
            wb_regSrc_q   <= wb_regSrc_d;
            wb_regWrite_q <= wb_regWrite_d;
            wb_writeReg_q <= wb_writeReg_d;
            wb_halt_q     <= wb_halt_d;
        end
    end

    // Request lines derive from state, so the async reset clears them at once; read wins if both flags were set.
    assign mem_rd    = (state_q == ACCESS) &  acc_rd_q;
    assign mem_wr    = (state_q == ACCESS) & ~acc_rd_q;
    assign mem_addr  = (state_q == ACCESS) ? acc_addr_q  : '0;
    assign mem_wdata = (state_q == ACCESS) ? acc_wdata_q : '0;
    assign stall     = rst & stall_c;
    assign err       = err_q;

    assign wb_valid    = wb_valid_q;
    assign wb_PC       = wb_PC_q;
    assign wb_readData = wb_readData_q;
    assign wb_aluOut   = wb_aluOut_q;
    assign wb_specOps  = wb_specOps_q;
    assign wb_regSrc   = wb_regSrc_q;
    assign wb_regWrite = wb_regWrite_q;
    assign wb_writeReg = wb_writeReg_q;
    assign wb_halt     = wb_halt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, load/store handshakes, back-to-back issue,
// reset during an access, misalignment and halt behaviour.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ex_PC;
    logic [15:0] ex_aluOut;
    logic [15:0] ex_specOps;
    logic [15:0] ex_storeData;
    logic        ex_memRead;
    logic        ex_memWrite;
    logic [1:0]  ex_regSrc;
    logic        ex_regWrite;
    logic [2:0]  ex_writeReg;
    logic        ex_halt;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        wb_valid;
    logic [15:0] wb_PC;
    logic [15:0] wb_readData;
    logic [15:0] wb_aluOut;
    logic [15:0] wb_specOps;
    logic [1:0]  wb_regSrc;
    logic        wb_regWrite;
    logic [2:0]  wb_writeReg;
    logic        wb_halt;
    logic        stall;
    logic        err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_PC       (ex_PC),
        .ex_aluOut   (ex_aluOut),
        .ex_specOps  (ex_specOps),
        .ex_storeData(ex_storeData),
        .ex_memRead  (ex_memRead),
        .ex_memWrite (ex_memWrite),
        .ex_regSrc   (ex_regSrc),
        .ex_regWrite (ex_regWrite),
        .ex_writeReg (ex_writeReg),
        .ex_halt     (ex_halt),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_rdata   (mem_rdata),
        .mem_done    (mem_done),
        .wb_valid    (wb_valid),
        .wb_PC       (wb_PC),
        .wb_readData (wb_readData),
        .wb_aluOut   (wb_aluOut),
        .wb_specOps  (wb_specOps),
        .wb_regSrc   (wb_regSrc),
        .wb_regWrite (wb_regWrite),
        .wb_writeReg (wb_writeReg),
        .wb_halt     (wb_halt),
        .stall       (stall),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [15:0] pc, input logic [15:0] alu,
                          input logic [15:0] sd, input logic rd, input logic wr,
                          input logic [1:0] src, input logic rw, input logic [2:0] wreg,
                          input logic hlt);
        ex_valid     = v;
        ex_PC        = pc;
        ex_aluOut    = alu;
        ex_specOps   = pc ^ 16'h5A5A;
        ex_storeData = sd;
        ex_memRead   = rd;
        ex_memWrite  = wr;
        ex_regSrc    = src;
        ex_regWrite  = rw;
        ex_writeReg  = wreg;
        ex_halt      = hlt;
    endtask

    initial begin
        rst       = 1'b0;
        mem_rdata = '0;
        mem_done  = 1'b0;
        // A memop presented during reset must not raise stall.
        set_ex(1, 16'h0000, 16'h0040, 16'h0000, 1, 0, 2'd1, 1, 3'd1, 0);
        #2;
        chk("rst_stall", {15'd0, stall}, 16'd0);
        chk("rst_wb_valid", {15'd0, wb_valid}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_mem_rd", {15'd0, mem_rd}, 16'd0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        tick();
        tick();
        set_ex(0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 2'd0, 0, 3'd0, 0);
        rst = 1'b1;

        // Pass-through ALU op
        set_ex(1, 16'h0100, 16'h1234, 16'h0000, 0, 0, 2'd2, 1, 3'd3, 0);
        #1;
        chk("pt_stall_idle", {15'd0, stall}, 16'd0);
        tick();
        chk("pt_wb_valid", {15'd0, wb_valid}, 16'd1);
        chk("pt_wb_aluOut", wb_aluOut, 16'h1234);
        chk("pt_wb_writeReg", {13'd0, wb_writeReg}, 16'd3);
        chk("pt_wb_regSrc", {14'd0, wb_regSrc}, 16'd2);
        chk("pt_wb_PC", wb_PC, 16'h0100);
        chk("pt_wb_specOps", wb_specOps, 16'h5B5A);
        chk("pt_wb_readData", wb_readData, 16'h0000);
        chk("pt_stall_after", {15'd0, stall}, 16'd0);

        set_ex(0, 16'h0100, 16'h1234, 16'h0000, 0, 0, 2'd2, 1, 3'd3, 0);
        tick();
        chk("bubble_wb_valid", {15'd0, wb_valid}, 16'd0);
        chk("bubble_wb_regWrite", {15'd0, wb_regWrite}, 16'd0);

        // Load with a 3-cycle memory, followed by an ALU op
        set_ex(1, 16'h0200, 16'h0040, 16'h0000, 1, 0, 2'd1, 1, 3'd5, 0);
        #1;
        chk("ld_stall_idle", {15'd0, stall}, 16'd1);
        chk("ld_mem_rd_idle", {15'd0, mem_rd}, 16'd0);
        tick();
        chk("ld_wb_valid_acc", {15'd0, wb_valid}, 16'd0);
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                mem_done  = 1'b1;
                mem_rdata = 16'hBEEF;
            end
            #1;
            chk($sformatf("ld_mem_rd_c%0d", c), {15'd0, mem_rd}, 16'd1);
            chk($sformatf("ld_mem_wr_c%0d", c), {15'd0, mem_wr}, 16'd0);
            chk($sformatf("ld_mem_addr_c%0d", c), mem_addr, 16'h0040);
            chk($sformatf("ld_stall_c%0d", c), {15'd0, stall}, (c == 3) ? 16'd0 : 16'd1);
            tick();
        end
        mem_done  = 1'b0;
        mem_rdata = 16'h0000;
        set_ex(1, 16'h0204, 16'h7777, 16'h0000, 0, 0, 2'd0, 1, 3'd6, 0);
        chk("ld_wb_valid", {15'd0, wb_valid}, 16'd1);
        chk("ld_wb_readData", wb_readData, 16'hBEEF);
        chk("ld_wb_writeReg", {13'd0, wb_writeReg}, 16'd5);
        chk("ld_wb_PC", wb_PC, 16'h0200);
        chk("ld_mem_rd_after", {15'd0, mem_rd}, 16'd0);
        #1;
        chk("b2b_stall", {15'd0, stall}, 16'd0);
        tick();
        set_ex(0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 2'd0, 0, 3'd0, 0);
        chk("b2b_wb_valid", {15'd0, wb_valid}, 16'd1);
        chk("b2b_wb_aluOut", wb_aluOut, 16'h7777);
        chk("b2b_wb_writeReg", {13'd0, wb_writeReg}, 16'd6);
        chk("b2b_wb_readData", wb_readData, 16'h0000);
        tick();
        chk("b2b_no_dup", {15'd0, wb_valid}, 16'd0);

        // Store completing on the first access cycle; mem_done is already high in IDLE
        mem_done = 1'b1;
        set_ex(1, 16'h0300, 16'h0010, 16'hA5A5, 0, 1, 2'd0, 0, 3'd0, 0);
        #1;
        chk("st_stall_idle", {15'd0, stall}, 16'd1);
        chk("st_mem_wr_idle", {15'd0, mem_wr}, 16'd0);
        tick();
        #1;
        chk("st_mem_wr", {15'd0, mem_wr}, 16'd1);
        chk("st_mem_rd", {15'd0, mem_rd}, 16'd0);
        chk("st_mem_wdata", mem_wdata, 16'hA5A5);
        chk("st_mem_addr", mem_addr, 16'h0010);
        chk("st_stall", {15'd0, stall}, 16'd0);
        tick();
        mem_done = 1'b0;
        set_ex(0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 2'd0, 0, 3'd0, 0);
        chk("st_wb_valid", {15'd0, wb_valid}, 16'd1);
        chk("st_wb_readData", wb_readData, 16'h0000);
        chk("st_wb_aluOut", wb_aluOut, 16'h0010);
        chk("st_mem_wr_after", {15'd0, mem_wr}, 16'd0);
        tick();

        // Reset asserted on the second access cycle
        set_ex(1, 16'h0400, 16'h0080, 16'h0000, 1, 0, 2'd1, 1, 3'd4, 0);
        tick();
        tick();
        #1;
        chk("ra_mem_rd_before", {15'd0, mem_rd}, 16'd1);
        rst = 1'b0;
        #1;
        chk("ra_mem_rd", {15'd0, mem_rd}, 16'd0);
        chk("ra_mem_addr", mem_addr, 16'h0000);
        chk("ra_wb_valid", {15'd0, wb_valid}, 16'd0);
        chk("ra_err", {15'd0, err}, 16'd0);
        chk("ra_stall", {15'd0, stall}, 16'd0);
        tick();
        rst = 1'b1;
        set_ex(1, 16'h0500, 16'h2222, 16'h0000, 0, 0, 2'd2, 1, 3'd7, 0);
        #1;
        chk("ra_pt_stall", {15'd0, stall}, 16'd0);
        tick();
        chk("ra_pt_wb_valid", {15'd0, wb_valid}, 16'd1);
        chk("ra_pt_wb_aluOut", wb_aluOut, 16'h2222);

        // Misaligned load traps into HALTED
        set_ex(1, 16'h0600, 16'h0041, 16'h0000, 1, 0, 2'd1, 1, 3'd2, 0);
        #1;
        chk("ma_mem_rd_idle", {15'd0, mem_rd}, 16'd0);
        tick();
        set_ex(0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 2'd0, 0, 3'd0, 0);
        mem_done = 1'b1;
        chk("ma_err", {15'd0, err}, 16'd1);
        chk("ma_wb_halt", {15'd0, wb_halt}, 16'd1);
        chk("ma_wb_regWrite", {15'd0, wb_regWrite}, 16'd0);
        chk("ma_wb_valid", {15'd0, wb_valid}, 16'd1);
        chk("ma_mem_rd", {15'd0, mem_rd}, 16'd0);
        chk("ma_stall", {15'd0, stall}, 16'd1);
        tick();
        chk("hl_wb_valid", {15'd0, wb_valid}, 16'd0);
        chk("hl_stall", {15'd0, stall}, 16'd1);
        chk("hl_err_sticky", {15'd0, err}, 16'd1);
        chk("hl_mem_rd", {15'd0, mem_rd}, 16'd0);
        mem_done = 1'b0;
        rst = 1'b0;
        #1;
        chk("hl_rst_err", {15'd0, err}, 16'd0);
        chk("hl_rst_wb_halt", {15'd0, wb_halt}, 16'd0);
        chk("hl_rst_stall", {15'd0, stall}, 16'd0);
        tick();
        rst = 1'b1;

        // Halt outranks a store issued alongside it
        set_ex(1, 16'h0700, 16'h0020, 16'h1111, 0, 1, 2'd0, 0, 3'd0, 1);
        #1;
        chk("ht_stall_idle", {15'd0, stall}, 16'd0);
        tick();
        set_ex(1, 16'h0704, 16'h3333, 16'h0000, 0, 0, 2'd2, 1, 3'd1, 0);
        chk("ht_wb_halt", {15'd0, wb_halt}, 16'd1);
        chk("ht_wb_valid", {15'd0, wb_valid}, 16'd1);
        chk("ht_err", {15'd0, err}, 16'd0);
        chk("ht_mem_wr", {15'd0, mem_wr}, 16'd0);
        chk("ht_stall", {15'd0, stall}, 16'd1);
        tick();
        chk("ht_wb_valid_after", {15'd0, wb_valid}, 16'd0);
        chk("ht_mem_wr_after", {15'd0, mem_wr}, 16'd0);
        chk("ht_wb_aluOut_held", wb_aluOut, 16'h0020);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset).
REQ-003 SHALL have inputs ex_valid 1, ex_PC 16, ex_aluOut 16, ex_specOps 16, ex_storeData 16, ex_memRead 1, ex_memWrite 1, ex_regSrc 2, ex_regWrite 1, ex_writeReg 3, ex_halt 1, all from the EX/MEM register.
REQ-004 SHALL have outputs mem_addr 16, mem_wdata 16, mem_rd 1, mem_wr 1, and inputs mem_rdata 16, mem_done 1, forming the data-memory handshake.
REQ-005 SHALL have outputs wb_valid 1, wb_PC 16, wb_readData 16, wb_aluOut 16, wb_specOps 16, wb_regSrc 2, wb_regWrite 1, wb_writeReg 3, wb_halt 1, all registered, feeding the write-back stage.
REQ-006 SHALL have outputs stall 1 (hold EX/MEM and earlier stages) and err 1 (sticky misalignment flag).

Function
REQ-007 SHALL implement states IDLE, ACCESS, HALTED.
REQ-008 SHALL treat an IDLE-cycle input as memop when ex_valid & (ex_memRead | ex_memWrite), and as misaligned when memop & ex_aluOut[0]=1.
REQ-009 In IDLE, a valid non-memop SHALL load the wb_* registers with the ex_* fields (wb_readData=0, wb_valid=1) at the next edge; latency 1 cycle, stall=0.
REQ-010 In IDLE, an aligned memop SHALL assert stall combinationally that cycle, latch address, store data, direction, and the WB fields, and enter ACCESS; wb_valid=0 at that edge.
REQ-011 In ACCESS, mem_addr, mem_wdata, mem_rd/mem_wr SHALL be driven from latched values and held stable until mem_done=1; mem_rd and mem_wr never both 1; both 0 outside ACCESS.
REQ-012 In ACCESS with mem_done=0: stall=1, state unchanged, ex_* ignored.
REQ-013 In ACCESS with mem_done=1: stall=0; at the edge, wb_* loaded from latched fields, wb_readData=mem_rdata for reads (0 for writes), wb_valid=1, return to IDLE.
REQ-014 ex_* SHALL be ignored in any ACCESS cycle, including the mem_done cycle (upstream advances at that edge; the next instruction is sampled in IDLE next cycle).
REQ-015 A misaligned memop SHALL issue no memory request, set err=1, load wb_* with wb_regWrite=0, wb_halt=1, wb_valid=1, and enter HALTED.
REQ-016 A valid ex_halt in IDLE SHALL load wb_* with wb_halt=1, wb_valid=1 and enter HALTED; halt takes priority over memop (no memory access).
REQ-017 In HALTED: stall=1, wb_valid=0 from the following edge, no memory requests; exit only by reset.
REQ-018 ex_valid=0 in IDLE SHALL produce wb_valid=0, wb_regWrite=0, wb_halt=0 at the next edge.
REQ-019 mem_done outside ACCESS SHALL be ignored.

Reset
REQ-020 rst=0 SHALL immediately force state IDLE, all wb_* outputs to 0, err=0, mem_rd=mem_wr=0, mem_addr=mem_wdata=0, stall=0, regardless of clk.
REQ-021 Reset asserted during ACCESS SHALL abandon the request with no WB update; first post-reset cycle is IDLE.

Verification
REQ-022 Pass-through: ex_valid=1, ex_aluOut=16'h1234, ex_regSrc=2, ex_writeReg=3, no memop -> next cycle wb_valid=1, wb_aluOut=16'h1234, wb_writeReg=3, stall never 1.
REQ-023 Load, 3-cycle memory: ex_memRead=1, ex_aluOut=16'h0040; mem_done=1 on 3rd ACCESS cycle, mem_rdata=16'hBEEF -> mem_rd=1, mem_addr=16'h0040 for 3 cycles, stall=1 for 3 cycles then 0, wb_readData=16'hBEEF, wb_valid=1 one cycle after done.
REQ-024 Store: ex_memWrite=1, ex_aluOut=16'h0010, ex_storeData=16'hA5A5, mem_done=1 on 1st ACCESS cycle -> mem_wr=1, mem_wdata=16'hA5A5 one cycle, wb_readData=0, wb_valid=1.
REQ-025 Misaligned: ex_memRead=1, ex_aluOut=16'h0041 -> mem_rd stays 0, err=1, wb_halt=1, wb_regWrite=0, then HALTED with stall=1, wb_valid=0.
REQ-026 Reset mid-access: rst=0 on 2nd ACCESS cycle -> mem_rd=0, wb_valid=0, err=0 immediately; after release a pass-through instruction completes in 1 cycle.
REQ-027 Back-to-back: load then ALU op held upstream during stall -> ALU op appears on wb_* exactly one cycle after the load's WB cycle, never duplicated.
